// File: rtl/dmem_sync.sv
// dmem_sync: word-organised data memory behind a valid/ready request/response handshake,
// with a programmable number of wait states between accept and response.
module dmem_sync #(
    parameter int RAM_BYTES   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(RAM_BYTES);
    localparam int WORDS = RAM_BYTES / 4;
    localparam logic [3:0] CNT_LOAD = WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Contents start at zero and deliberately survive rst.
    logic [31:0] mem [WORDS] = '{default: '0};

    logic          accept, access, in_range, acc_wr;
    logic [31:0]   acc_addr, acc_wdata;
    logic [3:0]    acc_mask;
    logic [AW-3:0] idx;

    // With zero wait states the access happens on the accept edge, so it uses the live request.
    always_comb begin
        accept    = req_valid && req_ready;
        acc_wr    = state_q == IDLE ? req_wr    : wr_q;
        acc_addr  = state_q == IDLE ? req_addr  : addr_q;
        acc_wdata = state_q == IDLE ? req_wdata : wdata_q;
        acc_mask  = state_q == IDLE ? req_mask  : mask_q;
        access    = !rst && (state_q == IDLE ? accept && WAIT_STATES == 0
                                             : state_q == WAIT && cnt_q == 4'd0);
        in_range  = acc_addr < 32'(RAM_BYTES);
        idx       = acc_addr[AW-1:2];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = WAIT_STATES == 0 ? RESP : WAIT;
                cnt_d   = CNT_LOAD;
                wr_d    = req_wr;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                mask_d  = req_mask;
            end
            WAIT: begin
                state_d = cnt_q == 4'd0 ? RESP : WAIT;
                cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
            end
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        if (access) begin
            rdata_d = acc_wr || !in_range ? 32'd0 : mem[idx];
            err_d   = !in_range;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (access && acc_wr && in_range)
            for (int b = 0; b < 4; b++)
                if (acc_mask[b]) mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
    end

    always_comb begin
        req_ready = state_q == IDLE;
        rsp_valid = state_q == RESP;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end
endmodule

// File: tb/tb_dmem_sync.sv
// tb_dmem_sync: scoreboard bench for dmem_sync; instance 0 has 1 wait state,
// instance 1 has 3 and instance 2 has 0, all with 1024 bytes of memory.
module tb_dmem_sync;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_wr    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_mask  [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [32:0] sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_sync #(.RAM_BYTES(1024), .WAIT_STATES(g == 0 ? 1 : g == 1 ? 3 : 0)) dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_wr(req_wr[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_mask(req_mask[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
        );
    end

    // Presents one request, waits for its accept and first response cycle; completes with rsp_ready=1.
    task automatic xact(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output logic [32:0] got, output int lat);
        int n;
        @(negedge clk);
        req_valid[k] = 1'b1; req_wr[k] = w; req_addr[k] = a; req_wdata[k] = d; req_mask[k] = m;
        rsp_ready[k] = 1'b1;
        n = 0;
        while (!req_ready[k] && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid[k] = 1'b0;
        lat = 1;
        while (!rsp_valid[k] && lat < 50) begin @(negedge clk); lat++; end
        got = {rsp_err[k], rsp_rdata[k]};
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b1; req_wr[k] = 1'b1; req_addr[k] = 32'h0; req_wdata[k] = 32'hFFFF_FFFF;
            req_mask[k] = 4'hF; rsp_ready[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({req_ready[k], rsp_valid[k], rsp_err[k], rsp_rdata[k]} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
                n_bad++;
                $display("FAIL reset[%0d]: got rdy=%b vld=%b err=%b rdata=%h want rdy=1 vld=0 err=0 rdata=0",
                         k, req_ready[k], rsp_valid[k], rsp_err[k], rsp_rdata[k]);
            end
            req_valid[k] = 1'b0;
        end
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        logic [32:0] got, exp;
        int lat;
        sb.push_back({1'b0, 32'h0});
        xact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, got, lat);
        exp = sb.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL st_rsp: got %h want %h", got, exp); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL st_lat: got %0d want 2", lat); end
        sb.push_back({1'b0, 32'hDEAD_BEEF});
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, got, lat);
        exp = sb.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL ld_rsp: got %h want %h", got, exp); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL ld_lat: got %0d want 2", lat); end
    endtask

    task automatic test_mask();
        logic [32:0] got, exp;
        int lat;
        sb.push_back({1'b0, 32'h0});
        xact(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, got, lat);
        exp = sb.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL mask_st1: got %h want %h", got, exp); end
        sb.push_back({1'b0, 32'h0});
        xact(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, got, lat);
        exp = sb.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL mask_st2: got %h want %h", got, exp); end
        sb.push_back({1'b0, 32'h11BB_33DD});
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, got, lat);
        exp = sb.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL mask_ld: got %h want %h", got, exp); end
        sb.push_back({1'b0, 32'h0});
        xact(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, got, lat);
        exp = sb.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL mask0_st: got %h want %h", got, exp); end
        sb.push_back({1'b0, 32'h11BB_33DD});
        xact(0, 1'b0, 32'h23, 32'h0, 4'h0, got, lat);
        exp = sb.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL mask0_ld: got %h want %h", got, exp); end
    endtask

    task automatic test_backpressure();
        logic [32:0] got, exp;
        int n, lat;
        @(negedge clk);
        req_valid[0] = 1'b1; req_wr[0] = 1'b0; req_addr[0] = 32'h10; req_mask[0] = 4'h0; rsp_ready[0] = 1'b0;
        n = 0;
        while (!req_ready[0] && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_wr[0] = 1'b1; req_wdata[0] = 32'h0; req_mask[0] = 4'hF;
        lat = 1;
        while (!rsp_valid[0] && lat < 50) begin @(negedge clk); lat++; end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL bp_lat: got %0d want 2", lat); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({rsp_valid[0], req_ready[0], rsp_err[0], rsp_rdata[0]} !== {1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b err=%b rdata=%h want vld=1 rdy=0 err=0 rdata=deadbeef",
                         i, rsp_valid[0], req_ready[0], rsp_err[0], rsp_rdata[0]);
            end
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        n_cmp++;
        if ({rsp_valid[0], req_ready[0]} !== 2'b01) begin
            n_bad++; $display("FAIL bp_done: got vld=%b rdy=%b want vld=0 rdy=1", rsp_valid[0], req_ready[0]);
        end
        sb.push_back({1'b0, 32'hDEAD_BEEF});
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, got, lat);
        exp = sb.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL bp_reload: got %h want %h", got, exp); end
    endtask

    task automatic test_out_of_range();
        logic [32:0] got, exp;
        int lat;
        sb.push_back({1'b1, 32'h0});
        xact(0, 1'b0, 32'h400, 32'h0, 4'h0, got, lat);
        exp = sb.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL oor_ld: got %h want %h", got, exp); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL oor_lat: got %0d want 2", lat); end
        sb.push_back({1'b1, 32'h0});
        xact(0, 1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, got, lat);
        exp = sb.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL oor_st: got %h want %h", got, exp); end
        sb.push_back({1'b0, 32'h0});
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, got, lat);
        exp = sb.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL oor_word0: got %h want %h", got, exp); end
        sb.push_back({1'b1, 32'h0});
        xact(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, got, lat);
        exp = sb.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL oor_top: got %h want %h", got, exp); end
        sb.push_back({1'b0, 32'h0});
        xact(0, 1'b1, 32'h3FC, 32'h1234_5678, 4'hF, got, lat);
        exp = sb.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL last_st: got %h want %h", got, exp); end
        sb.push_back({1'b0, 32'h1234_5678});
        xact(0, 1'b0, 32'h3FC, 32'h0, 4'h0, got, lat);
        exp = sb.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL last_ld: got %h want %h", got, exp); end
    endtask

    task automatic test_reset_wait();
        logic [32:0] got;
        int n, lat;
        @(negedge clk);
        req_valid[1] = 1'b1; req_wr[1] = 1'b1; req_addr[1] = 32'h30; req_wdata[1] = 32'h55;
        req_mask[1] = 4'hF; rsp_ready[1] = 1'b1;
        n = 0;
        while (!req_ready[1] && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req_valid[1] = 1'b1; req_wr[1] = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({rsp_valid[1], req_ready[1]} !== 2'b01) begin
            n_bad++; $display("FAIL rw_inrst: got vld=%b rdy=%b want vld=0 rdy=1", rsp_valid[1], req_ready[1]);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready[1] !== 1'b0) begin n_bad++; $display("FAIL rw_first_acc: got rdy=%b want 0", req_ready[1]); end
        req_valid[1] = 1'b0;
        lat = 1;
        while (!rsp_valid[1] && lat < 50) begin @(negedge clk); lat++; end
        sb.push_back({1'b0, 32'h0});
        got = {rsp_err[1], rsp_rdata[1]};
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL rw_lat: got %0d want 4", lat); end
        n_cmp++; if (got !== sb[0]) begin n_bad++; $display("FAIL rw_ld: got %h want %h", got, sb[0]); end
        void'(sb.pop_front());
    endtask

    task automatic test_reset_resp();
        logic [32:0] got, exp;
        int n, lat;
        @(negedge clk);
        req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 32'h40; req_wdata[0] = 32'hCAFE_F00D;
        req_mask[0] = 4'hF; rsp_ready[0] = 1'b0;
        n = 0;
        while (!req_ready[0] && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid[0] = 1'b0;
        n = 0;
        while (!rsp_valid[0] && n < 50) begin @(negedge clk); n++; end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (rsp_valid[0] !== 1'b0) begin n_bad++; $display("FAIL rr_drop: got vld=%b want 0", rsp_valid[0]); end
        rst = 1'b0;
        rsp_ready[0] = 1'b1;
        sb.push_back({1'b0, 32'hCAFE_F00D});
        xact(0, 1'b0, 32'h40, 32'h0, 4'h0, got, lat);
        exp = sb.pop_front();
        n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rr_kept: got %h want %h", got, exp); end
    endtask

    task automatic test_back_to_back();
        logic [32:0] got, exp;
        int lat, j, last;
        for (int i = 0; i < 4; i++) begin
            sb.push_back({1'b0, 32'h0});
            xact(2, 1'b1, 32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF, got, lat);
            exp = sb.pop_front();
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL b2b_st[%0d]: got %h want %h", i, got, exp); end
            n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL b2b_st_lat[%0d]: got %0d want 1", i, lat); end
        end
        @(negedge clk);
        req_valid[2] = 1'b1; req_wr[2] = 1'b0; req_addr[2] = 32'h100; rsp_ready[2] = 1'b1;
        j = 0;
        last = -1;
        for (int i = 0; i < 14; i++) begin
            if (rsp_valid[2]) begin
                got = {rsp_err[2], rsp_rdata[2]};
                exp = sb.size() > 0 ? sb.pop_front() : 33'h1_FFFF_FFFF;
                n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL b2b_ld: got %h want %h", got, exp); end
                n_cmp++; if (cyc !== last) begin n_bad++; $display("FAIL b2b_lat: rsp at cycle %0d want %0d", cyc, last); end
            end
            if (req_ready[2] && req_valid[2]) begin
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc + 1 - last !== 2) begin n_bad++; $display("FAIL b2b_gap: got %0d want 2", cyc + 1 - last); end
                end
                sb.push_back({1'b0, 32'hB000_0000 + 32'(j)});
                last = cyc + 1;
                j++;
            end else begin
                req_valid[2] = j < 4;
                req_addr[2] = 32'h100 + 32'(4 * j);
            end
            @(negedge clk);
        end
        req_valid[2] = 1'b0;
        n_cmp++; if (j !== 4) begin n_bad++; $display("FAIL b2b_count: got %0d accepts want 4", j); end
        n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL b2b_drain: got %0d pending want 0", sb.size()); end
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_mask();
        test_backpressure();
        test_out_of_range();
        test_reset_wait();
        test_reset_resp();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_sync.md
DMEM_SYNC -- requirements
Module: dmem_sync

Interface
REQ-001 The module SHALL have parameter RAM_BYTES, default 1024, meaning data memory size in bytes (power of two, minimum 16).
REQ-002 The module SHALL have parameter WAIT_STATES, default 1, meaning extra cycles between request accept and response (legal range 0..15).
REQ-003 The module SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, meaning the reset: asynchronous, active-high.
REQ-005 The module SHALL have port req_valid, input, 1 bit, meaning a request is presented.
REQ-006 The module SHALL have port req_ready, output, 1 bit, meaning the block can accept a request this cycle.
REQ-007 The module SHALL have port req_wr, input, 1 bit, meaning 1 = store, 0 = load.
REQ-008 The module SHALL have port req_addr, input, 32 bits, meaning the byte address (bits [1:0] ignored, word aligned).
REQ-009 The module SHALL have port req_wdata, input, 32 bits, meaning the store data.
REQ-010 The module SHALL have port req_mask, input, 4 bits, meaning the byte-lane write enables, bit n = byte n.
REQ-011 The module SHALL have port rsp_valid, output, 1 bit, meaning a response is presented.
REQ-012 The module SHALL have port rsp_ready, input, 1 bit, meaning the requester accepts the response.
REQ-013 The module SHALL have port rsp_rdata, output, 32 bits, meaning the load data (full word).
REQ-014 The module SHALL have port rsp_err, output, 1 bit, meaning the address was out of range.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP; req_ready=1 only in IDLE.
REQ-016 Accept SHALL occur when req_valid&&req_ready at an edge; req_wr, req_addr, req_wdata and req_mask are captured into internal registers at that edge.
REQ-017 On accept, next state SHALL be WAIT with counter loaded to WAIT_STATES-1 if WAIT_STATES>0, else RESP.
REQ-018 In WAIT, the counter SHALL decrement each cycle; when the counter is 0, next state SHALL be RESP.
REQ-019 The memory access SHALL execute at the edge entering RESP: store writes masked lanes; load samples word index addr[log2(RAM_BYTES)-1:2] into rsp_rdata.
REQ-020 rsp_valid SHALL first assert exactly WAIT_STATES+1 cycles after the accept edge.
REQ-021 In RESP, rsp_valid=1 and rsp_rdata/rsp_err SHALL be held stable until rsp_ready=1; at that edge next state SHALL be IDLE.
REQ-022 A new request SHALL NOT be accepted in the cycle rsp_ready completes a response (ready rises the following cycle); maximum throughput is one request per WAIT_STATES+2 cycles.
REQ-023 A store response SHALL drive rsp_rdata=0.
REQ-024 A store with req_mask=4'b0000 SHALL leave memory unchanged and respond with rsp_err=0.
REQ-025 If req_addr >= RAM_BYTES, the block SHALL perform no memory access and SHALL respond with rsp_err=1 and rsp_rdata=0, with the same timing.
REQ-026 Word index SHALL use only addr bits [log2(RAM_BYTES)-1:2]; there SHALL be no wrap-around aliasing, since out-of-range addresses are errored.
REQ-027 A load following a store to the same word SHALL return the stored data (no stale read).
REQ-028 Memory contents SHALL initialise to zero at time 0 and SHALL NOT be cleared by rst.

Reset
REQ-029 While rst=1, the block SHALL hold state IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0 and rsp_err=0, regardless of clk.
REQ-030 If rst asserts in WAIT, the pending store SHALL be discarded (memory unchanged) and no response SHALL be issued.
REQ-031 If rst asserts in RESP, the response SHALL be dropped; the already-committed write SHALL remain.
REQ-032 req_valid SHALL be ignored during rst, and the first accept SHALL be possible at the first edge after rst deasserts.

Verification
REQ-033 WAIT_STATES=1, RAM_BYTES=1024: store addr 0x10, data 0xDEADBEEF, mask 4'b1111, then load 0x10 -> rsp_valid 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-034 Mask test: store 0x11223344 to 0x20 mask 4'b1111, then store 0xAABBCCDD mask 4'b0101, then load 0x20 -> 0x11BB33DD.
REQ-035 Backpressure: hold rsp_ready=0 for 5 cycles during a load of 0x10 -> rsp_valid and rdata stable all 5 cycles, req_ready=0 throughout, and a new req_valid is not accepted.
REQ-036 Out-of-range: load 0x400 with RAM_BYTES=1024 -> rsp_err=1, rdata 0; store 0x400 -> memory word 0 is unchanged.
REQ-037 Reset mid-op: WAIT_STATES=3, store 0x55 to 0x30, assert rst on the second WAIT cycle -> no rsp_valid, and a later load of 0x30 returns 0.
REQ-038 WAIT_STATES=0: back-to-back load requests with rsp_ready tied 1 -> rsp_valid 1 cycle after each accept, and accepts spaced exactly 2 cycles apart.
